// File: rtl/pll_reconfig_bridge_pkg.sv
// Shared types for the PAL/NTSC PLL configuration path: bridge states,
// reconfig register map and the address/data record used by the writer.
package pll_cfg_pkg;

  localparam int CFG_AW = 6;
  localparam int CFG_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FWD       = 2'd1,
    ST_WAIT_LOCK = 2'd2,
    ST_SETTLE    = 2'd3
  } pll_br_state_t;

  localparam logic [CFG_AW-1:0] ADDR_MODE  = 6'h00;
  localparam logic [CFG_AW-1:0] ADDR_START = 6'h02;
  localparam logic [CFG_AW-1:0] ADDR_N     = 6'h03;
  localparam logic [CFG_AW-1:0] ADDR_M     = 6'h04;
  localparam logic [CFG_AW-1:0] ADDR_C     = 6'h05;
  localparam logic [CFG_AW-1:0] ADDR_MFRAC = 6'h07;
  localparam logic [CFG_AW-1:0] ADDR_BW    = 6'h08;
  localparam logic [CFG_AW-1:0] ADDR_CP    = 6'h09;

  typedef struct packed {
    logic [CFG_AW-1:0] addr;
    logic [CFG_DW-1:0] data;
  } pll_cfg_rec_t;

endpackage

// File: rtl/pll_reconfig_bridge_if.sv
// Upstream config bus and downstream PLL reconfig management bus.
// Handshake: a write transfers on a cycle where write=1 and waitrequest=0;
// while waitrequest=1 the initiator holds write, address and data unchanged.
interface pll_reconfig_bridge_if;
  import pll_cfg_pkg::*;

  logic              cfg_write;
  logic [CFG_AW-1:0] cfg_address;
  logic [CFG_DW-1:0] cfg_data;
  logic              cfg_waitrequest;
  logic              mgmt_write;
  logic [CFG_AW-1:0] mgmt_address;
  logic [CFG_DW-1:0] mgmt_writedata;
  logic              mgmt_waitrequest;

  // slave: the bridge; master: the writer and the reconfig IP around it
  modport slave (
    input  cfg_write, cfg_address, cfg_data, mgmt_waitrequest,
    output cfg_waitrequest, mgmt_write, mgmt_address, mgmt_writedata
  );

  modport master (
    output cfg_write, cfg_address, cfg_data, mgmt_waitrequest,
    input  cfg_waitrequest, mgmt_write, mgmt_address, mgmt_writedata
  );

endinterface

// File: rtl/pll_reconfig_bridge_sync2.sv
// Two-flop synchroniser for a slow level signal crossing into clk.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_bridge.sv
// Forwards config writes to the PLL reconfig IP one at a time and holds the
// core in reset after a Start write until lock has been stable long enough.
module pll_reconfig_bridge
  import pll_cfg_pkg::*;
#(
  parameter logic [CFG_AW-1:0] START_ADDR    = ADDR_START,
  parameter int                SETTLE_CYCLES = 256,
  parameter int                LOCK_TIMEOUT  = 1048576
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  pll_reconfig_bridge_if.slave   bus,
  input  logic                   pll_locked,
  output logic                   core_reset,
  output logic                   busy,
  output logic                   lock_err,
  output pll_br_state_t          dbg_state
);

  localparam int TO_W = $clog2(LOCK_TIMEOUT);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

  pll_br_state_t     state, state_d;
  logic [CFG_AW-1:0] addr_q, addr_d;
  logic [CFG_DW-1:0] data_q, data_d;
  logic              core_reset_q, core_reset_d;
  logic              lock_err_q, lock_err_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d, to_inc;
  logic [ST_W-1:0]   st_cnt, st_cnt_d, st_inc;
  logic              lk;
  logic              accept;

  sync2 u_lock_sync (
    .clk (clk_sys),
    .rst (reset),
    .d   (pll_locked),
    .q   (lk)
  );

  assign bus.cfg_waitrequest = (state != ST_IDLE) | reset | !lk;
  assign accept              = bus.cfg_write & !bus.cfg_waitrequest;
  assign bus.mgmt_write      = (state == ST_FWD);
  assign bus.mgmt_address    = addr_q;
  assign bus.mgmt_writedata  = data_q;
  assign core_reset          = core_reset_q;
  assign lock_err            = lock_err_q;
  assign busy                = (state != ST_IDLE);
  assign dbg_state           = state;

  // Both counters saturate instead of wrapping.
  assign to_inc = (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);
  assign st_inc = (st_cnt == '1) ? st_cnt : st_cnt + ST_W'(1);

  always_comb begin
    state_d      = state;
    addr_d       = addr_q;
    data_d       = data_q;
    core_reset_d = core_reset_q;
    lock_err_d   = lock_err_q;
    to_cnt_d     = to_cnt;
    st_cnt_d     = st_cnt;
    case (state)
      ST_IDLE: begin
        // Lock loss wins over a pending write, which stays stalled.
        if (!lk) begin
          state_d      = ST_WAIT_LOCK;
          core_reset_d = 1'b1;
          to_cnt_d     = '0;
        end else if (accept) begin
          state_d = ST_FWD;
          addr_d  = bus.cfg_address;
          data_d  = bus.cfg_data;
          if (bus.cfg_address == START_ADDR) begin
            core_reset_d = 1'b1;
            lock_err_d   = 1'b0;
          end
        end
      end
      ST_FWD: begin
        if (!bus.mgmt_waitrequest) begin
          if (addr_q == START_ADDR) begin
            state_d  = ST_WAIT_LOCK;
            to_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_LOCK: begin
        if (!bus.mgmt_waitrequest && lk) begin
          state_d  = ST_SETTLE;
          st_cnt_d = '0;
          to_cnt_d = to_inc;
        end else if (to_cnt >= TO_LAST) begin
          state_d      = ST_IDLE;
          lock_err_d   = 1'b1;
          core_reset_d = 1'b0;
        end else begin
          to_cnt_d = to_inc;
        end
      end
      ST_SETTLE: begin
        // A lock drop restarts settling but not the overall timeout.
        if (!lk) begin
          state_d  = ST_WAIT_LOCK;
          st_cnt_d = '0;
          to_cnt_d = to_inc;
        end else if (st_cnt >= ST_LAST) begin
          state_d      = ST_IDLE;
          core_reset_d = 1'b0;
        end else begin
          st_cnt_d = st_inc;
          to_cnt_d = to_inc;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= ST_WAIT_LOCK;
      addr_q       <= '0;
      data_q       <= '0;
      core_reset_q <= 1'b1;
      lock_err_q   <= 1'b0;
      to_cnt       <= '0;
      st_cnt       <= '0;
    end else begin
      state        <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      core_reset_q <= core_reset_d;
      lock_err_q   <= lock_err_d;
      to_cnt       <= to_cnt_d;
      st_cnt       <= st_cnt_d;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_bridge.sv
// Bench for pll_reconfig_bridge with a short settle time and lock timeout.
module tb_pll_reconfig_bridge;
  import pll_cfg_pkg::*;

  localparam int SC = 4;
  localparam int LT = 64;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          pll_locked;
  logic          core_reset;
  logic          busy;
  logic          lock_err;
  pll_br_state_t dbg_state;

  pll_reconfig_bridge_if bus ();

  pll_reconfig_bridge #(
    .START_ADDR    (ADDR_START),
    .SETTLE_CYCLES (SC),
    .LOCK_TIMEOUT  (LT)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .pll_locked (pll_locked),
    .core_reset (core_reset),
    .busy       (busy),
    .lock_err   (lock_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;
  int hi_cnt  = 0;
  logic [37:0] exp_q[$];

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          exp_wait;
    logic        exp_core_reset;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: called just after a rising edge, returns just after the accept edge
  task automatic do_write(input logic [5:0] a, input logic [31:0] d, output int waited);
    bit done;
    waited = 0;
    done   = 1'b0;
    bus.cfg_write   = 1'b1;
    bus.cfg_address = a;
    bus.cfg_data    = d;
    while (!done && waited < 100) begin
      @(negedge clk_sys);
      if (!bus.cfg_waitrequest) begin
        exp_q.push_back({a, d});
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk_sys);
      #1;
    end
    if (!done) check("accept_timeout", 1, 0);
    bus.cfg_write = 1'b0;
  endtask

  task automatic wait_release(input int exp_k, input string name);
    int k;
    bit done;
    k    = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      k++;
      if (!core_reset) done = 1'b1;
    end
    check({name, "_latency"}, k, exp_k);
    check({name, "_waitreq"}, bus.cfg_waitrequest, 0);
    check({name, "_busy"}, busy, 0);
    @(posedge clk_sys);
    #1;
  endtask

  // scoreboard: every completed mgmt transfer pops one expected record
  logic        prev_wr = 1'b0;
  logic [37:0] prev_ad = '0;
  always @(negedge clk_sys) begin
    if (bus.mgmt_write) begin
      hi_cnt++;
      if (prev_wr) check("mgmt_stable", {bus.mgmt_address, bus.mgmt_writedata}, prev_ad);
      if (!bus.mgmt_waitrequest) begin
        if (exp_q.size() == 0) check("mgmt_unexpected", {bus.mgmt_address, bus.mgmt_writedata}, 0);
        else check("mgmt_xfer", {bus.mgmt_address, bus.mgmt_writedata}, exp_q.pop_front());
      end
    end
    prev_wr = bus.mgmt_write;
    prev_ad = {bus.mgmt_address, bus.mgmt_writedata};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0] = '{ADDR_MODE,  32'h0000_0000, 0, 1'b0};
    vecs[1] = '{ADDR_N,     32'h0002_0101, 1, 1'b0};
    vecs[2] = '{ADDR_M,     32'h0001_0808, 1, 1'b0};
    vecs[3] = '{ADDR_C,     32'h0000_0505, 1, 1'b0};
    vecs[4] = '{ADDR_C,     32'h0004_0A0A, 1, 1'b0};
    vecs[5] = '{ADDR_C,     32'h0008_1414, 1, 1'b0};
    vecs[6] = '{ADDR_MFRAC, 32'h6D3A_06D4, 1, 1'b0};
    vecs[7] = '{ADDR_BW,    32'h0000_0007, 1, 1'b0};
    vecs[8] = '{ADDR_CP,    32'h0000_0002, 1, 1'b0};
    vecs[9] = '{ADDR_START, 32'h0000_0001, 1, 1'b1};

    reset                = 1'b1;
    pll_locked           = 1'b1;
    bus.cfg_write        = 1'b0;
    bus.cfg_address      = '0;
    bus.cfg_data         = '0;
    bus.mgmt_waitrequest = 1'b0;

    // reset values
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_core_reset", core_reset, 1);
    check("rst_mgmt_write", bus.mgmt_write, 0);
    check("rst_mgmt_addr", bus.mgmt_address, 0);
    check("rst_mgmt_data", bus.mgmt_writedata, 0);
    check("rst_waitreq", bus.cfg_waitrequest, 1);
    check("rst_busy", busy, 1);
    check("rst_lock_err", lock_err, 0);
    check("rst_state", dbg_state, ST_WAIT_LOCK);
    @(posedge clk_sys);
    #1 reset = 1'b0;
    wait_release(SC + 3, "powerup");

    // burst of writer-sequence writes, no mgmt stall
    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].addr, vecs[i].data, w);
      check($sformatf("burst%0d_wait", i), w, vecs[i].exp_wait);
      check($sformatf("burst%0d_core_reset", i), core_reset, vecs[i].exp_core_reset);
    end
    wait_release(SC + 2, "burst");
    check("burst_drained", exp_q.size(), 0);

    // mgmt stall for 5 cycles on a write to M
    bus.mgmt_waitrequest = 1'b1;
    hi_cnt = 0;
    do_write(ADDR_M, 32'hDEAD_0004, w);
    repeat (5) @(posedge clk_sys);
    #1 bus.mgmt_waitrequest = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("stall_hi_cycles", hi_cnt, 6);
    check("stall_drained", exp_q.size(), 0);
    check("stall_core_reset", core_reset, 0);

    // lock glitch during SETTLE restarts the settle count
    do_write(ADDR_START, 32'h0000_0001, w);
    check("glitch_core_reset_set", core_reset, 1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_sys);
      #1;
      if (k == 2) pll_locked = 1'b0;
      if (k == 3) pll_locked = 1'b1;
      @(negedge clk_sys);
      check($sformatf("glitch_core_reset_k%0d", k), core_reset, (k < 10));
      if (k == 5) check("glitch_state_k5", dbg_state, ST_WAIT_LOCK);
    end
    @(posedge clk_sys);
    #1;

    // lock timeout with lock lost right at the Start write
    pll_locked = 1'b0;
    do_write(ADDR_START, 32'h0000_0001, w);
    for (int k = 1; k <= LT + 2; k++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (k == LT) begin
        check("to_lock_err_before", lock_err, 0);
        check("to_core_reset_before", core_reset, 1);
      end
      if (k == LT + 1) begin
        check("to_lock_err", lock_err, 1);
        check("to_core_reset", core_reset, 0);
        check("to_state", dbg_state, ST_IDLE);
      end
      if (k == LT + 2) begin
        check("idle_lockloss_core_reset", core_reset, 1);
        check("idle_lockloss_state", dbg_state, ST_WAIT_LOCK);
        check("idle_lockloss_waitreq", bus.cfg_waitrequest, 1);
      end
    end
    @(posedge clk_sys);
    #1 pll_locked = 1'b1;
    wait_release(SC + 3, "relock");
    check("lock_err_sticky", lock_err, 1);
    do_write(ADDR_START, 32'h0000_0001, w);
    check("lock_err_cleared", lock_err, 0);
    wait_release(SC + 2, "restart");

    // reset while FWD is stalled
    bus.mgmt_waitrequest = 1'b1;
    do_write(ADDR_N, 32'h0000_0033, w);
    check("fwd_state", dbg_state, ST_FWD);
    reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("midrst_mgmt_write", bus.mgmt_write, 0);
    check("midrst_core_reset", core_reset, 1);
    check("midrst_state", dbg_state, ST_WAIT_LOCK);
    check("midrst_pending", exp_q.size(), 1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(posedge clk_sys);
    #1;
    reset                = 1'b0;
    bus.mgmt_waitrequest = 1'b0;
    wait_release(SC + 3, "midrst");
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
